gf2_div_iter: RTL and testbench



---
 rtl/gf2_pkg.sv | 28 ++
 rtl/gf2_mul.sv | 22 ++
 rtl/gf2_div_iter.sv | 106 ++++++++++
 tb/tb_gf2_div_iter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2_pkg.sv
// Shared definitions for the GF(2^N) tower-field normal-basis arithmetic blocks.
// GF(4) basis [W, W^2] (bit1 = W), GF(16) basis [Z^4, Z] over GF(4) (bits 3:2 = Z^4).
package gf2_pkg;

    typedef enum logic [2:0] {IDLE, SQ, MUL, FIN, DONE} state_e;

    // Norm of Z over GF(4): W^2, which keeps x^2 + x + NU irreducible.
    localparam logic [1:0] GF4_NU = 2'b01;

    function automatic int num_ops(int n);
        return 2 * n - 2;
    endfunction

    function automatic bit n_is_legal(int n);
        return (n == 2) || (n == 4);
    endfunction

    function automatic logic [3:0] gf_one(int n);
        return 4'((1 << n) - 1);
    endfunction

    function automatic logic [1:0] gf4_mul(logic [1:0] a, logic [1:0] b);
        logic e;
        e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
    endfunction

endpackage

// File: rtl/gf2_mul.sv
// Combinational GF(2^N) multiplier, N = 2 or 4, normal basis at every tower level.
module gf2_mul
    import gf2_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_p
);

    if (N == 2) begin : g_gf4
        assign o_p = gf4_mul(i_a, i_b);
    end else begin : g_gf16
        logic [1:0] w_e;
        // Cross term shared by both halves, scaled by the norm of Z.
        assign w_e = gf4_mul(gf4_mul(i_a[3:2] ^ i_a[1:0], i_b[3:2] ^ i_b[1:0]), GF4_NU);
        assign o_p = {gf4_mul(i_a[3:2], i_b[3:2]) ^ w_e,
                      gf4_mul(i_a[1:0], i_b[1:0]) ^ w_e};
    end

endmodule

// File: rtl/gf2_div_iter.sv
// Sequential GF(2^N) divider: Q = A * B^(2^N-2) via square-and-multiply on one
// shared multiplier, with valid/ready handshakes on both sides.
module gf2_div_iter
    import gf2_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         ClkxCI,
    input  logic         RstxBI,
    input  logic [N-1:0] AxDI,
    input  logic [N-1:0] BxDI,
    input  logic         InValidxSI,
    output logic         InReadyxSO,
    output logic [N-1:0] QxDO,
    output logic         DivZeroxSO,
    output logic         OutValidxSO,
    input  logic         OutReadyxSI
);

    if (!n_is_legal(N)) begin : g_bad_n
        $error("gf2_div_iter: N must be 2 or 4");
    end

    // Number of SQ->MUL rounds before the last square; equals N-2.
    localparam logic [1:0] CNT_INIT = 2'(num_ops(N) / 2 - 1);

    state_e       r_state;
    logic [N-1:0] r_r;
    logic [N-1:0] r_a;
    logic [N-1:0] r_bs;
    logic [1:0]   r_cnt;
    logic         r_dz;
    logic         r_vld;

    logic [N-1:0] w_op_x;
    logic [N-1:0] w_op_y;
    logic [N-1:0] w_prod;

    always_comb begin
        w_op_x = r_r;
        w_op_y = r_r;
        case (r_state)
            MUL:     w_op_y = r_bs;
            FIN:     w_op_x = r_a;
            default: ;
        endcase
    end

    gf2_mul #(.N(N)) u_mul (
        .i_a (w_op_x),
        .i_b (w_op_y),
        .o_p (w_prod)
    );

    always_ff @(posedge ClkxCI) begin
        if (!RstxBI) begin
            r_state <= IDLE;
            r_r     <= '0;
            r_a     <= '0;
            r_bs    <= '0;
            r_cnt   <= '0;
            r_dz    <= 1'b0;
            r_vld   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (InValidxSI) begin
                    r_a     <= AxDI;
                    r_r     <= BxDI;
                    r_bs    <= BxDI;
                    r_dz    <= (BxDI == '0);
                    r_cnt   <= CNT_INIT;
                    r_state <= SQ;
                end
                SQ: begin
                    r_r     <= w_prod;
                    r_state <= (r_cnt != 2'd0) ? MUL : FIN;
                end
                MUL: begin
                    r_r     <= w_prod;
                    r_cnt   <= r_cnt - 2'd1;
                    r_state <= SQ;
                end
                FIN: begin
                    r_r     <= w_prod;
                    r_state <= DONE;
                end
                DONE: begin
                    // First DONE cycle registers the valid flag; result is then held.
                    if (!r_vld) begin
                        r_vld <= 1'b1;
                    end else if (OutReadyxSI) begin
                        r_vld   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign InReadyxSO  = (r_state == IDLE);
    assign QxDO        = r_r;
    assign DivZeroxSO  = r_dz;
    assign OutValidxSO = r_vld;

endmodule

// File: tb/tb_gf2_div_iter.sv
// Directed and exhaustive checks of gf2_div_iter for N=2 and N=4.
module tb_gf2_div_iter;

    logic       clk;
    logic       rst_n;
    logic [1:0] a2, b2, q2;
    logic       iv2, ir2, dz2, ov2, or2;
    logic [3:0] a4, b4, q4;
    logic       iv4, ir4, dz4, ov4, or4;

    int n_checks = 0;
    int n_fail   = 0;

    gf2_div_iter #(.N(2)) dut2 (
        .ClkxCI(clk), .RstxBI(rst_n), .AxDI(a2), .BxDI(b2), .InValidxSI(iv2),
        .InReadyxSO(ir2), .QxDO(q2), .DivZeroxSO(dz2), .OutValidxSO(ov2), .OutReadyxSI(or2)
    );

    gf2_div_iter #(.N(4)) dut4 (
        .ClkxCI(clk), .RstxBI(rst_n), .AxDI(a4), .BxDI(b4), .InValidxSI(iv4),
        .InReadyxSO(ir4), .QxDO(q4), .DivZeroxSO(dz4), .OutValidxSO(ov4), .OutReadyxSI(or4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference GF(4) arithmetic by discrete log: W=10, W^2=01, 1=11.
    function automatic int lg4(logic [1:0] x);
        case (x)
            2'b11:   return 0;
            2'b10:   return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [1:0] ex4(int k);
        case (k % 3)
            0:       return 2'b11;
            1:       return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [1:0] m4(logic [1:0] x, logic [1:0] y);
        if (x == 2'b00 || y == 2'b00) return 2'b00;
        return ex4(lg4(x) + lg4(y));
    endfunction

    // Reference GF(16) product from the basis table (Z^4, Z), Z^2 + Z + NU = 0.
    function automatic logic [3:0] tb_mul16(logic [3:0] x, logic [3:0] y);
        logic [1:0] hh, ll, cr, nu, onu;
        nu  = 2'b01;
        onu = 2'b11 ^ nu;
        hh  = m4(x[3:2], y[3:2]);
        ll  = m4(x[1:0], y[1:0]);
        cr  = m4(x[3:2], y[1:0]) ^ m4(x[1:0], y[3:2]);
        return {m4(hh, onu) ^ m4(ll, nu) ^ m4(cr, nu),
                m4(hh, nu) ^ m4(ll, onu) ^ m4(cr, nu)};
    endfunction

    task automatic div4(input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] q, output logic dz, output int lat);
        a4 = a; b4 = b; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        q = q4; dz = dz4;
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
    endtask

    task automatic div2(input logic [1:0] a, input logic [1:0] b,
                        output logic [1:0] q, output logic dz, output int lat);
        a2 = a; b2 = b; iv2 = 1'b1;
        @(posedge clk); #1;
        iv2 = 1'b0;
        lat = 0;
        while (!ov2 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        q = q2; dz = dz2;
        or2 = 1'b1;
        @(posedge clk); #1;
        or2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ir4, ov4, q4, dz4} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_n4: got ir=%b ov=%b q=%h dz=%b expected ir=1 ov=0 q=0 dz=0", ir4, ov4, q4, dz4);
        end
        n_checks++;
        if ({ir2, ov2, q2, dz2} !== {1'b1, 1'b0, 2'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_n2: got ir=%b ov=%b q=%h dz=%b expected ir=1 ov=0 q=0 dz=0", ir2, ov2, q2, dz2);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_n2();
        logic [1:0] q;
        logic       dz;
        int         lat;
        div2(2'h3, 2'h1, q, dz, lat);
        n_checks++;
        if ({q, dz} !== {2'h2, 1'b0} || lat != 3) begin
            n_fail++;
            $display("FAIL n2_3div1: got q=%h dz=%b lat=%0d expected q=2 dz=0 lat=3", q, dz, lat);
        end
        div2(2'h1, 2'h2, q, dz, lat);
        n_checks++;
        if ({q, dz} !== {2'h2, 1'b0} || lat != 3) begin
            n_fail++;
            $display("FAIL n2_1div2: got q=%h dz=%b lat=%0d expected q=2 dz=0 lat=3", q, dz, lat);
        end
    endtask

    task automatic test_n4_basic();
        logic [3:0] q;
        logic       dz;
        int         lat;
        div4(4'h6, 4'h6, q, dz, lat);
        n_checks++;
        if ({q, dz} !== {4'hF, 1'b0} || lat != 7) begin
            n_fail++;
            $display("FAIL n4_6div6: got q=%h dz=%b lat=%0d expected q=f dz=0 lat=7", q, dz, lat);
        end
        div4(4'h9, 4'hF, q, dz, lat);
        n_checks++;
        if ({q, dz} !== {4'h9, 1'b0} || lat != 7) begin
            n_fail++;
            $display("FAIL n4_9divF: got q=%h dz=%b lat=%0d expected q=9 dz=0 lat=7", q, dz, lat);
        end
    endtask

    task automatic test_zero();
        logic [3:0] q;
        logic       dz;
        int         lat;
        div4(4'h5, 4'h0, q, dz, lat);
        n_checks++;
        if ({q, dz} !== {4'h0, 1'b1} || lat != 7) begin
            n_fail++;
            $display("FAIL zero_div: got q=%h dz=%b lat=%0d expected q=0 dz=1 lat=7", q, dz, lat);
        end
        div4(4'h0, 4'hA, q, dz, lat);
        n_checks++;
        if ({q, dz} !== {4'h0, 1'b0} || lat != 7) begin
            n_fail++;
            $display("FAIL zero_dividend: got q=%h dz=%b lat=%0d expected q=0 dz=0 lat=7", q, dz, lat);
        end
    endtask

    task automatic test_exhaustive();
        logic [3:0] q, a, b;
        logic       dz;
        int         lat;
        bit         ok;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                a = 4'(ia);
                b = 4'(ib);
                div4(a, b, q, dz, lat);
                if (b == 4'h0) ok = (q === 4'h0) && (dz === 1'b1);
                else           ok = (tb_mul16(q, b) === a) && (dz === 1'b0);
                n_checks++;
                if (!ok || lat != 7) begin
                    n_fail++;
                    $display("FAIL exhaustive a=%h b=%h: got q=%h dz=%b lat=%0d q*b=%h expected q*b=a (q=0 dz=1 if b=0) lat=7",
                             a, b, q, dz, lat, tb_mul16(q, b));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int cnt;
        a4 = 4'h9; b4 = 4'hF; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        cnt = 0;
        while (!ov4 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({ov4, ir4, q4, dz4} !== {1'b1, 1'b0, 4'h9, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold cyc=%0d: got ov=%b ir=%b q=%h dz=%b expected ov=1 ir=0 q=9 dz=0", i, ov4, ir4, q4, dz4);
            end
            iv4 = i[0];
            a4  = 4'(i);
            b4  = 4'(i + 3);
            @(posedge clk); #1;
        end
        iv4 = 1'b0;
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
        n_checks++;
        if ({ov4, ir4} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_release: got ov=%b ir=%b expected ov=0 ir=1", ov4, ir4);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({ov4, ir4} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_idle: got ov=%b ir=%b expected ov=0 ir=1", ov4, ir4);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] q;
        logic       dz;
        int         lat;
        a4 = 4'h6; b4 = 4'h6; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4   = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({ir4, ov4, q4} !== {1'b1, 1'b0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_mid: got ir=%b ov=%b q=%h expected ir=1 ov=0 q=0", ir4, ov4, q4);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        div4(4'h6, 4'h6, q, dz, lat);
        n_checks++;
        if ({q, dz} !== {4'hF, 1'b0} || lat != 7) begin
            n_fail++;
            $display("FAIL reset_mid_resume: got q=%h dz=%b lat=%0d expected q=f dz=0 lat=7", q, dz, lat);
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        a4 = 4'h9; b4 = 4'hF; iv4 = 1'b1; or4 = 1'b1;
        @(posedge clk); #1;
        cnt = 0;
        while (!ir4 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_checks++;
        if (cnt != 8) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d cycles to ready expected 8", cnt);
        end
        a4 = 4'h6; b4 = 4'h6;
        @(posedge clk); #1;
        iv4 = 1'b0;
        cnt = 0;
        while (!ov4 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_checks++;
        if (q4 !== 4'hF || cnt != 7) begin
            n_fail++;
            $display("FAIL b2b_second: got q=%h lat=%0d expected q=f lat=7", q4, cnt);
        end
        @(posedge clk); #1;
        or4 = 1'b0;
    endtask

    initial begin
        a2 = '0; b2 = '0; iv2 = 1'b0; or2 = 1'b0;
        a4 = '0; b4 = '0; iv4 = 1'b0; or4 = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_n2();
        test_n4_basic();
        test_zero();
        test_exhaustive();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
